spi_sram_responder: RTL and testbench

// - SPI mode-0 target emulating a 23LC-style serial SRAM: the far end of the core's instruction/data SPI masters.
// - Backs an on-chip byte array and decodes READ (0x03) and WRITE (0x02) commands.
// - Used in the test harness or as a chip-level scratch memory.
// - Runs off the system clock and oversamples SCK/CS/MOSI, so it does not run on the SPI clock.

---
 rtl/spi_sram_pkg.sv | 22 ++
 rtl/spi_in_sync.sv | 58 +++++
 rtl/spi_sram_responder.sv | 210 +++++++++++++++++++++
 tb/tb_spi_sram_responder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared types and command codes for the SPI serial-SRAM responder.
package spi_sram_pkg;

  // Responder protocol phase for one chip-select window.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_IGNORE  = 3'd5
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // True for the command bytes this responder implements.
  function automatic logic is_supported_cmd(input logic [7:0] cmd);
    return (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchroniser for the asynchronous SPI pins plus edge detection on SCK
// and CS. MOSI runs through a chain of the same length so it stays aligned
// with the SCK edge pulses.
module spi_in_sync #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_act,
  output logic mosi_s
);

  logic [SYNC_STG-1:0] sck_ch;
  logic [SYNC_STG-1:0] cs_ch;
  logic [SYNC_STG-1:0] mosi_ch;
  logic                sck_h;
  logic                cs_h;

  // Synchroniser chains and one history flop for SCK and CS; CS idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_ch  <= '0;
      cs_ch   <= '1;
      mosi_ch <= '0;
      sck_h   <= 1'b0;
      cs_h    <= 1'b1;
    end else begin
      sck_ch[0]  <= sck;
      cs_ch[0]   <= cs_n;
      mosi_ch[0] <= mosi;
      for (int i = 1; i < SYNC_STG; i++) begin
        sck_ch[i]  <= sck_ch[i-1];
        cs_ch[i]   <= cs_ch[i-1];
        mosi_ch[i] <= mosi_ch[i-1];
      end
      sck_h <= sck_ch[SYNC_STG-1];
      cs_h  <= cs_ch[SYNC_STG-1];
    end
  end

  // Single-clock edge pulses from the synchronised level and its history.
  always_comb begin
    sck_rise = sck_ch[SYNC_STG-1] & ~sck_h;
    sck_fall = ~sck_ch[SYNC_STG-1] & sck_h;
    cs_fall  = ~cs_ch[SYNC_STG-1] & cs_h;
    cs_rise  = cs_ch[SYNC_STG-1] & ~cs_h;
    cs_act   = ~cs_ch[SYNC_STG-1];
    mosi_s   = mosi_ch[SYNC_STG-1];
  end

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 target emulating a 23LC-style serial SRAM (READ 0x03 /
// WRITE 0x02) over an on-chip byte array. Everything runs on clk; the SPI
// pins are oversampled.
//
// Backdoor port: bd_we writes bd_wdata to mem[bd_addr] at the clock edge
// where it is high (an SPI write to the same address in that edge wins);
// bd_rdata always returns mem[bd_addr] one clock after bd_addr is
// presented, so a backdoor write is observable two clocks later.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int MEM_AW   = 8,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              busy,
  output logic              cmd_err,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int CNT_W = $clog2((ADDR_W > 8) ? ADDR_W : 8);

  logic sck_rise, sck_fall, cs_fall, cs_rise, cs_act, mosi_s;

  spi_in_sync #(
    .SYNC_STG (SYNC_STG)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (spi_sck),
    .cs_n     (spi_cs_n),
    .mosi     (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .cs_act   (cs_act),
    .mosi_s   (mosi_s)
  );

  logic [7:0]        mem [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [6:0]        sh_q;       // command / write-data bits received so far
  logic              rd_q;       // current transaction is a READ
  logic [MEM_AW-1:0] ptr_q;
  logic [7:0]        tx_latch;   // next byte to present on MISO
  logic [7:0]        tx_sh;
  logic              miso_q;
  logic              load_pend;  // next sck_fall loads tx_latch

  logic [7:0]        rx_byte;
  logic [MEM_AW-1:0] addr_next;
  logic [MEM_AW-1:0] ptr_inc;
  logic              byte_edge;
  logic              last_cmd;
  logic              last_addr;
  logic              spi_we;

  // Event decode shared by the FSM, the datapath and the array write port.
  always_comb begin
    rx_byte   = {sh_q, mosi_s};
    addr_next = {ptr_q[MEM_AW-2:0], mosi_s};
    ptr_inc   = ptr_q + MEM_AW'(1);
    byte_edge = sck_rise && (bit_cnt == CNT_W'(7));
    last_cmd  = (state_q == ST_CMD) && byte_edge;
    last_addr = (state_q == ST_ADDR) && sck_rise && (bit_cnt == CNT_W'(ADDR_W - 1));
    spi_we    = (state_q == ST_WR_DATA) && byte_edge && !cs_rise;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: CS release returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD:  if (last_cmd) state_d = is_supported_cmd(rx_byte) ? ST_ADDR : ST_IGNORE;
      ST_ADDR: if (last_addr) state_d = rd_q ? ST_RD_DATA : ST_WR_DATA;
      default: state_d = state_q;
    endcase
    if (cs_rise) state_d = ST_IDLE;
  end

  // FSM outputs: MISO is only driven during a read with CS still asserted.
  always_comb begin
    spi_miso_oe = (state_q == ST_RD_DATA) && cs_act;
    spi_miso    = spi_miso_oe & miso_q;
    busy        = cs_act;
  end

  // Shift registers, counters, pointer and MISO bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      sh_q      <= '0;
      rd_q      <= 1'b0;
      ptr_q     <= '0;
      tx_latch  <= '0;
      tx_sh     <= '0;
      miso_q    <= 1'b0;
      load_pend <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (cs_rise) begin
        bit_cnt   <= '0;
        sh_q      <= '0;
        miso_q    <= 1'b0;
        load_pend <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              bit_cnt <= '0;
              sh_q    <= '0;
              miso_q  <= 1'b0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              sh_q    <= {sh_q[5:0], mosi_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_cmd) begin
                bit_cnt <= '0;
                rd_q    <= (rx_byte == CMD_READ);
                cmd_err <= !is_supported_cmd(rx_byte);
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              ptr_q   <= addr_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (last_addr) begin
                bit_cnt <= '0;
                if (rd_q) begin
                  tx_latch  <= mem[addr_next];
                  load_pend <= 1'b1;
                end
              end
            end
          end
          ST_RD_DATA: begin
            if (sck_fall) begin
              if (load_pend) begin
                tx_sh     <= tx_latch;
                miso_q    <= tx_latch[7];
                load_pend <= 1'b0;
              end else begin
                tx_sh  <= {tx_sh[6:0], 1'b0};
                miso_q <= tx_sh[6];
              end
            end
            if (sck_rise) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (byte_edge) begin
                bit_cnt   <= '0;
                ptr_q     <= ptr_inc;
                tx_latch  <= mem[ptr_inc];
                load_pend <= 1'b1;
              end
            end
          end
          ST_WR_DATA: begin
            if (sck_rise) begin
              sh_q    <= {sh_q[5:0], mosi_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (byte_edge) begin
                bit_cnt <= '0;
                ptr_q   <= ptr_inc;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Array write port: SPI write is applied last so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (bd_we)  mem[bd_addr] <= bd_wdata;
    if (spi_we) mem[ptr_q]   <= rx_byte;
  end

  // Registered backdoor read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bd_rdata <= '0;
    else     bd_rdata <= mem[bd_addr];
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: bit-banged SPI master, backdoor access,
// expected-byte queue and a reference copy of the array.
module tb_spi_sram_responder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe, busy, cmd_err;
  logic       bd_we;
  logic [7:0] bd_addr, bd_wdata, bd_rdata;

  spi_sram_responder #(
    .ADDR_W   (24),
    .MEM_AW   (8),
    .SYNC_STG (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .bd_we       (bd_we),
    .bd_addr     (bd_addr),
    .bd_wdata    (bd_wdata),
    .bd_rdata    (bd_rdata)
  );

  // Clock
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_mem [256];
  logic [7:0] wr_buf[$];
  int         err_cycles = 0;
  int         oe_cycles = 0;

  // Count cmd_err and spi_miso_oe high cycles.
  always @(negedge clk) begin
    if (cmd_err)     err_cycles = err_cycles + 1;
    if (spi_miso_oe) oe_cycles  = oe_cycles + 1;
  end

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t preload [4];
  vec_t wr_chk  [3];
  vec_t al_chk  [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0h expected nothing (queue empty)", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic bd_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bd_addr = a;
    wait_clk(2);
    d = bd_rdata;
  endtask

  // One SCK period: MOSI set in the low phase, MISO sampled at the rise and
  // re-sampled at the end of the high phase.
  task automatic spi_bit(input logic mo, output logic mi, output logic stable);
    @(negedge clk);
    spi_mosi = mo;
    wait_clk(HALF - 1);
    mi      = spi_miso;
    spi_sck = 1'b1;
    wait_clk(HALF);
    stable  = (spi_miso === mi);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic stable);
    logic mi, st;
    stable = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], mi, st);
      rx[i]  = mi;
      stable = stable & st;
    end
  endtask

  task automatic spi_send(input logic [7:0] tx);
    logic [7:0] rx;
    logic       st;
    spi_byte(tx, rx, st);
  endtask

  task automatic spi_begin();
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_read(input logic [23:0] addr, input int nbytes, input string name);
    logic [7:0] rx;
    logic [7:0] a;
    logic       st;
    spi_begin();
    spi_send(8'h03);
    spi_send(addr[23:16]);
    spi_send(addr[15:8]);
    spi_send(addr[7:0]);
    a = addr[7:0];
    for (int i = 0; i < nbytes; i++) begin
      exp_q.push_back(model_mem[a]);
      a = a + 8'd1;
    end
    for (int i = 0; i < nbytes; i++) begin
      spi_byte(8'h00, rx, st);
      sb_check(name, rx);
      check({name, "_stable"}, st, 1);
    end
    check({name, "_oe"}, spi_miso_oe, 1);
    check({name, "_busy"}, busy, 1);
    spi_end();
    check({name, "_oe_after"}, spi_miso_oe, 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  task automatic spi_write(input logic [23:0] addr);
    logic [7:0] a;
    spi_begin();
    spi_send(8'h02);
    spi_send(addr[23:16]);
    spi_send(addr[15:8]);
    spi_send(addr[7:0]);
    a = addr[7:0];
    foreach (wr_buf[i]) begin
      spi_send(wr_buf[i]);
      model_mem[a] = wr_buf[i];
      a = a + 8'd1;
    end
    spi_end();
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] old21;
    logic [7:0] rx;
    logic       mi, st;
    logic [23:0] raddr;
    int          e0, o0;

    preload[0] = '{8'h10, 8'hA5};
    preload[1] = '{8'h11, 8'h3C};
    preload[2] = '{8'h12, 8'hFF};
    preload[3] = '{8'h13, 8'h01};
    wr_chk[0]  = '{8'hFE, 8'hDE};
    wr_chk[1]  = '{8'hFF, 8'hAD};
    wr_chk[2]  = '{8'h00, 8'hBE};
    al_chk[0]  = '{8'hFE, 8'h11};
    al_chk[1]  = '{8'hFF, 8'h22};
    al_chk[2]  = '{8'h00, 8'h33};

    // Reset with a random array, CS pulled low to show busy stays 0.
    rst      = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b0;
    spi_mosi = 1'b1;
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_wdata = '0;
    for (int i = 0; i < 256; i++) bd_write(8'(i), 8'($urandom_range(0, 255)));
    check("rst_miso", spi_miso, 0);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_bd_rdata", bd_rdata, 0);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    check("post_rst_miso", spi_miso, 0);
    check("post_rst_oe", spi_miso_oe, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_cmd_err", cmd_err, 0);

    // Backdoor read of random contents.
    for (int i = 0; i < 4; i++) begin
      raddr[7:0] = 8'($urandom_range(0, 255));
      bd_read(raddr[7:0], d);
      check("bd_rand_read", d, model_mem[raddr[7:0]]);
    end

    // Preload and stream-read four bytes.
    for (int i = 0; i < 4; i++) bd_write(preload[i].addr, preload[i].data);
    for (int i = 0; i < 4; i++) exp_q.push_back(preload[i].data);
    spi_begin();
    spi_send(8'h03);
    spi_send(8'h00);
    spi_send(8'h00);
    spi_send(8'h10);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx, st);
      sb_check("read_preload", rx);
      check("read_preload_stable", st, 1);
    end
    spi_end();

    // Streaming write with pointer wrap.
    wr_buf = '{8'hDE, 8'hAD, 8'hBE};
    spi_write(24'h0000FE);
    for (int i = 0; i < 3; i++) begin
      bd_read(wr_chk[i].addr, d);
      check("write_wrap", d, wr_chk[i].data);
    end

    // Upper wire address bits alias.
    wr_buf = '{8'h11, 8'h22, 8'h33};
    spi_write(24'h1234FE);
    for (int i = 0; i < 3; i++) begin
      bd_read(al_chk[i].addr, d);
      check("write_alias", d, al_chk[i].data);
    end

    // Read stream wrapping FF -> 00.
    spi_read(24'h0000FE, 3, "read_wrap");

    // Full byte then a partial byte: partial discarded.
    old21 = model_mem[8'h21];
    spi_begin();
    spi_send(8'h02);
    spi_send(8'h00);
    spi_send(8'h00);
    spi_send(8'h20);
    spi_send(8'h77);
    for (int i = 0; i < 5; i++) spi_bit(~old21[7-i], mi, st);
    spi_end();
    bd_read(8'h20, d);
    check("partial_full_byte", d, 8'h77);
    bd_read(8'h21, d);
    check("partial_discard", d, old21);

    // Unsupported command.
    e0 = err_cycles;
    o0 = oe_cycles;
    spi_begin();
    spi_send(8'h9F);
    spi_send(8'h00);
    spi_send(8'h00);
    spi_send(8'h10);
    spi_send(8'h00);
    check("bad_cmd_busy", busy, 1);
    spi_end();
    check("bad_cmd_err_pulse", err_cycles - e0, 1);
    check("bad_cmd_oe_held", oe_cycles - o0, 0);
    spi_read(24'h000010, 2, "read_after_bad");

    // Random reads against the model.
    for (int n = 0; n < 3; n++) begin
      raddr = 24'($urandom_range(0, 24'hFFFFFF));
      spi_read(raddr, $urandom_range(1, 4), "read_rand");
    end

    // Reset in the middle of a read after 12 data bits.
    spi_begin();
    spi_send(8'h03);
    spi_send(8'h00);
    spi_send(8'h00);
    spi_send(8'h10);
    spi_byte(8'h00, rx, st);
    check("midrst_first_byte", rx, 8'hA5);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, mi, st);
    check("midrst_oe_before", spi_miso_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_miso", spi_miso, 0);
    check("midrst_oe", spi_miso_oe, 0);
    check("midrst_busy", busy, 0);
    spi_cs_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(8);
    spi_read(24'h000010, 1, "read_after_rst");

    check("cmd_err_total", err_cycles, 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
